// File: rtl/mix_columns_seq.sv
// mix_columns_seq: iterative AES MixColumns / InvMixColumns engine.
// One 128-bit state is accepted per transaction. The state is transformed in
// place, COLS_PER_CYCLE columns per clock. The finished result is then held
// until the consumer takes it.
module mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   localparam int N = 4 / COLS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(N - 1);

   // Only 1, 2 or 4 columns per cycle divide the state evenly.
   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [127:0]       work_q, work_d;
   logic               mode_q, mode_d;

   // Multiply by x in GF(2^8), reducing by the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Transform one 32-bit column; row 0 sits in the most significant byte.
   function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
      logic [7:0] a  [4];
      logic [7:0] p2 [4];
      logic [7:0] p4 [4];
      logic [7:0] p8 [4];
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] y;
      logic [31:0] res;
      res = 32'h0;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         p2[i] = xtime(a[i]);
         p4[i] = xtime(p2[i]);
         p8[i] = xtime(p4[i]);
      end
      for (int r = 0; r < 4; r++) begin
         a0 = a[r];
         a1 = a[(r+1)%4];
         a2 = a[(r+2)%4];
         a3 = a[(r+3)%4];
         if (inv) begin
            // 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
            y = (p8[r] ^ p4[r] ^ p2[r])
              ^ (p8[(r+1)%4] ^ p2[(r+1)%4] ^ a1)
              ^ (p8[(r+2)%4] ^ p4[(r+2)%4] ^ a2)
              ^ (p8[(r+3)%4] ^ a3);
         end else begin
            // 02*a0 ^ 03*a1 ^ a2 ^ a3
            y = p2[r] ^ (p2[(r+1)%4] ^ a1) ^ a2 ^ a3;
         end
         res[31-8*r -: 8] = y;
      end
      return res;
   endfunction

   // State register: reset clears everything and aborts any transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state logic: capture in IDLE, transform one column group per BUSY cycle, hold in DONE.
   always_comb begin
      int col_idx;
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      mode_d  = mode_q;
      col_idx = 0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = in_data;
               mode_d  = in_inv;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
               col_idx = int'(cnt_q) * COLS_PER_CYCLE + j;
               work_d[127-32*col_idx -: 32] = mix_column(work_q[127-32*col_idx -: 32], mode_q);
            end
            if (cnt_q == LAST_GRP) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign out_data  = work_q;

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequential, parametrised MixColumns/InvMixColumns engine for the AES datapath. It accepts one 128-bit state per transaction over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock, trading area for latency. A per-transaction mode bit selects the forward or inverse transform. It sits between ShiftRows/InvShiftRows and AddRoundKey in the iterative round core.

## Interface
- COLS_PER_CYCLE, default 1: columns transformed per clock; legal values 1, 2, 4. Any other value is a static configuration error.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data/in_inv valid.
- in_ready  out  1  block can accept a state.
- in_data  in  128  input state.
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns; captured with in_data.
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  128  transformed state.

## Operation
- Byte layout (FIPS-197 order): column c = in_data[127-32c -: 32]; row 0 is the most significant byte of that word.
- Forward matrix rows: {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
- Inverse matrix rows: {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
- GF(2^8) arithmetic: xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0). Higher constants are built from xtime chains. All results are 8-bit with no carries.
- N = 4 / COLS_PER_CYCLE groups. The column counter is log2(N) bits and wraps to 0 after the last group.
- FSM states:
  - IDLE: in_ready=1. When in_valid is high, capture in_data into the work register, capture in_inv into the mode register, clear the counter, and go to BUSY.
  - BUSY: each cycle, replace columns [k·C, k·C+C-1] of the work register in place with their transform (C = COLS_PER_CYCLE, k = counter), then increment the counter. After group N-1, go to DONE.
  - DONE: out_valid=1. out_data and mode stay frozen. When out_ready is high, go to IDLE.
- in_ready is asserted only in IDLE. Input is ignored in BUSY and DONE, and in_data may change freely then.
- Mode is fixed per transaction. in_inv changes after acceptance have no effect.
- out_data always shows the work register. Its value is only defined while out_valid=1.

## Timing
- Reset, checked at the edge, overrides everything:
  - state → IDLE, counter → 0, work register → 0, mode → 0.
  - out_valid=0, out_data=128'h0.
  - in_ready=0 while rst is high, 1 on the first cycle after rst drops.
- Reset in BUSY or DONE aborts the transaction. No out_valid pulse follows.
- Latency: for an accept at edge E, out_valid rises after edge E+N (N = 4, 2 or 1).
- If out_ready is high in the first DONE cycle, the handshake completes at edge E+N+1 and in_ready returns after that edge. The next accept is at edge E+N+2 at the earliest.
- Peak throughput: one state per N+2 cycles.
- Back-pressure: out_valid and out_data hold indefinitely while out_ready=0.
- out_ready high outside DONE has no effect.
- in_valid and out_ready are never combinationally tied to each other. in_ready depends only on FSM state and rst.

## Test plan
- Forward transform, COLS_PER_CYCLE=1: in_data=db135345_f20a225c_01010101_2d26314c, in_inv=0 → out_data=8e4da1bc_9fdc589d_01010101_4d7ebdf8, out_valid rises 4 cycles after accept.
- Inverse transform: in_data=8e4da1bc_9fdc589d_01010101_4d7ebdf8, in_inv=1 → out_data=db135345_f20a225c_01010101_2d26314c. Repeat for COLS_PER_CYCLE=2 (latency 2) and 4 (latency 1).
- Fixed points and polynomial reduction: c6c6c6c6_01010101_d4d4d4d5_2d26314c forward → c6c6c6c6_01010101_d5d5d7d6_4d7ebdf8.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE and toggle in_valid/in_data/in_inv → out_data stable, in_ready=0, no second accept. Then raise out_ready → one handshake, IDLE next cycle.
- Reset mid-BUSY: with COLS_PER_CYCLE=1, assert rst for one cycle 2 cycles after accept → out_valid never rises, out_data=0, in_ready=1 the cycle after rst drops. A new transaction then produces the correct result.
- Random regression: 10k random states and modes, random out_ready stalls, all three parameter values. Compare against a reference model. Checks: inverse(forward(x))==x, in_ready and out_valid are never both high, and the N+2 accept spacing holds.
